scalar_mult_ctrl: RTL and testbench

- Left-to-right double-and-add scheduler for elliptic-curve scalar multiplication, Q = k·P.
- Sequences one shared group-operation unit through a start/done handshake. The unit wraps point addition and point doubling, selected by op_sel, with variable latency.
- Owns scalar bit scanning, point-at-infinity handling and the accumulator registers.
- Sits between the top-level scalar-multiply interface and the modular point-arithmetic datapath.

---
 rtl/scalar_mult_ctrl.sv | 178 +++++++++++++++++
 tb/tb_scalar_mult_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_mult_ctrl.sv
// Left-to-right double-and-add scheduler for Q = k*P, driving one shared
// add/double group-op unit through an op_start/op_done handshake.
module scalar_mult_ctrl #(
   parameter int n  = 231,
   parameter int IW = 8,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [n-1:0]  k,
   input  logic [n-1:0]  px,
   input  logic [n-1:0]  py,
   output logic          busy,
   output logic          done,
   output logic [n-1:0]  qx,
   output logic [n-1:0]  qy,
   output logic          q_inf,
   output logic          op_start,
   output logic          op_sel,
   output logic [n-1:0]  op_ax,
   output logic [n-1:0]  op_ay,
   output logic [n-1:0]  op_bx,
   output logic [n-1:0]  op_by,
   input  logic          op_done,
   input  logic [n-1:0]  op_rx,
   input  logic [n-1:0]  op_ry,
   output logic [CW-1:0] op_count
);

   typedef enum logic [2:0] {
      IDLE, SCAN, DBL_REQ, DBL_WAIT, ADD_REQ, ADD_WAIT, FIN
   } state_t;

   state_t state, next_state;

   logic          rst_meta, rst_n_int;
   logic [n-1:0]  k_reg;
   logic [n-1:0]  k_shifted;
   logic [IW-1:0] idx;
   logic          cur_bit;
   logic          idx_zero;

   // Reset asserts immediately but releases two clock edges later, so the
   // whole controller leaves reset on a clean edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_meta  <= 1'b0;
         rst_n_int <= 1'b0;
      end else begin
         rst_meta  <= 1'b1;
         rst_n_int <= rst_meta;
      end
   end

   assign k_shifted = k_reg >> idx;
   assign cur_bit   = k_shifted[0];
   assign idx_zero  = (idx == '0);

   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) state <= IDLE;
      else            state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (start) next_state = SCAN;
         SCAN: begin
            if (cur_bit)       next_state = idx_zero ? FIN : DBL_REQ;
            else if (idx_zero) next_state = FIN;
         end
         DBL_REQ:  next_state = DBL_WAIT;
         DBL_WAIT: begin
            if (op_done) begin
               if (cur_bit)       next_state = ADD_REQ;
               else if (idx_zero) next_state = FIN;
               else               next_state = DBL_REQ;
            end
         end
         ADD_REQ:  next_state = ADD_WAIT;
         ADD_WAIT: if (op_done) next_state = idx_zero ? FIN : DBL_REQ;
         FIN:      next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   always_comb begin
      busy     = 1'b0;
      done     = 1'b0;
      op_start = 1'b0;
      op_sel   = 1'b0;
      case (state)
         SCAN, ADD_WAIT: busy = 1'b1;
         DBL_REQ: begin
            busy     = 1'b1;
            op_start = 1'b1;
            op_sel   = 1'b1;
         end
         DBL_WAIT: begin
            busy   = 1'b1;
            op_sel = 1'b1;
         end
         ADD_REQ: begin
            busy     = 1'b1;
            op_start = 1'b1;
         end
         FIN:     done = 1'b1;
         default: ;
      endcase
   end

   // The operand-a registers track Q on every load, so they are already
   // stable when op_start is raised and hold through the wait.
   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         k_reg    <= '0;
         op_bx    <= '0;
         op_by    <= '0;
         op_ax    <= '0;
         op_ay    <= '0;
         qx       <= '0;
         qy       <= '0;
         q_inf    <= 1'b0;
         idx      <= '0;
         op_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  k_reg    <= k;
                  op_bx    <= px;
                  op_by    <= py;
                  idx      <= IW'(n - 1);
                  op_count <= '0;
                  q_inf    <= 1'b0;
               end
            end
            SCAN: begin
               if (cur_bit) begin
                  qx    <= op_bx;
                  qy    <= op_by;
                  op_ax <= op_bx;
                  op_ay <= op_by;
                  if (!idx_zero) idx <= idx - IW'(1);
               end else if (idx_zero) begin
                  q_inf <= 1'b1;
                  qx    <= '0;
                  qy    <= '0;
               end else begin
                  idx <= idx - IW'(1);
               end
            end
            DBL_REQ, ADD_REQ: op_count <= op_count + CW'(1);
            DBL_WAIT: begin
               if (op_done) begin
                  qx    <= op_rx;
                  qy    <= op_ry;
                  op_ax <= op_rx;
                  op_ay <= op_ry;
                  if (!cur_bit && !idx_zero) idx <= idx - IW'(1);
               end
            end
            ADD_WAIT: begin
               if (op_done) begin
                  qx    <= op_rx;
                  qy    <= op_ry;
                  op_ax <= op_rx;
                  op_ay <= op_ry;
                  if (!idx_zero) idx <= idx - IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Self-checking bench for scalar_mult_ctrl at n = 8, with a behavioural
// group-op unit that works on scalar tags (Q tag m means Q = m*P).
module tb_scalar_mult_ctrl;

   localparam int N  = 8;
   localparam int CW = 16;

   logic          clk;
   logic          reset;
   logic          start;
   logic [N-1:0]  k, px, py;
   logic          busy, done, q_inf, op_start, op_sel, op_done;
   logic [N-1:0]  qx, qy, op_ax, op_ay, op_bx, op_by, op_rx, op_ry;
   logic [CW-1:0] op_count;

   int passed = 0;
   int total  = 0;
   int op_lat = 1;

   bit         sel_log[$];
   logic [7:0] res_log[$];
   bit         exp_sel[$];

   typedef struct {
      logic [7:0] k;
      logic [7:0] px;
      logic [7:0] py;
      int         lat;
      int         mid_start;
      logic [7:0] eqx;
      logic [7:0] eqy;
      logic       einf;
      int         ecnt;
   } vec_t;

   vec_t vecs[8];

   scalar_mult_ctrl #(.n(N), .IW(8), .CW(CW)) dut (
      .clk(clk), .reset(reset), .start(start), .k(k), .px(px), .py(py),
      .busy(busy), .done(done), .qx(qx), .qy(qy), .q_inf(q_inf),
      .op_start(op_start), .op_sel(op_sel), .op_ax(op_ax), .op_ay(op_ay),
      .op_bx(op_bx), .op_by(op_by), .op_done(op_done), .op_rx(op_rx),
      .op_ry(op_ry), .op_count(op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural group-op unit: add returns a+b, double returns 2a, per
   // coordinate, after op_lat cycles.
   initial begin
      logic       s;
      logic [7:0] rx, ry;
      op_done = 1'b0;
      op_rx   = '0;
      op_ry   = '0;
      forever begin
         @(negedge clk);
         op_done = 1'b0;
         if (op_start === 1'b1) begin
            s = op_sel;
            sel_log.push_back(s);
            rx = s ? 8'(op_ax + op_ax) : 8'(op_ax + op_bx);
            ry = s ? 8'(op_ay + op_ay) : 8'(op_ay + op_by);
            repeat (op_lat) @(negedge clk);
            op_done = 1'b1;
            op_rx   = rx;
            op_ry   = ry;
            res_log.push_back(rx);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Reference: for each bit below the MSB one double, plus an add per set bit.
   task automatic buildExpected(input logic [7:0] kv, output int cnt);
      int msb = -1;
      exp_sel.delete();
      cnt = 0;
      for (int i = 7; i >= 0; i--) if (kv[i] && msb < 0) msb = i;
      for (int i = msb - 1; i >= 0; i--) begin
         exp_sel.push_back(1'b1);
         cnt++;
         if (kv[i]) begin
            exp_sel.push_back(1'b0);
            cnt++;
         end
      end
   endtask

   task automatic applyStimulus(input vec_t v, input string tag);
      int cycles;
      int mcnt;
      bit sel_ok;
      buildExpected(v.k, mcnt);
      op_lat = v.lat;
      sel_log.delete();
      res_log.delete();
      @(negedge clk);
      k = v.k; px = v.px; py = v.py; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = ~v.k; px = ~v.px; py = ~v.py;
      checkOutput({tag, " busy_after_start"}, busy, 1);
      cycles = 1;
      while (done !== 1'b1 && cycles < 3000) begin
         start = (cycles == v.mid_start);
         @(negedge clk);
         cycles++;
      end
      start = 1'b0;
      checkOutput({tag, " done_seen"}, done, 1);
      checkOutput({tag, " busy_on_done"}, busy, 0);
      checkOutput({tag, " qx"}, qx, v.eqx);
      checkOutput({tag, " qy"}, qy, v.eqy);
      checkOutput({tag, " q_inf"}, q_inf, v.einf);
      checkOutput({tag, " op_count"}, op_count, v.ecnt);
      checkOutput({tag, " op_count_model"}, op_count, mcnt);
      sel_ok = (sel_log.size() == exp_sel.size());
      if (sel_ok)
         foreach (exp_sel[i]) if (sel_log[i] != exp_sel[i]) sel_ok = 0;
      checkOutput({tag, " op_sel_seq"}, sel_ok, 1);
      if (v.k == 8'd0)
         checkOutput({tag, " zero_latency"}, cycles, 9);
      if (v.k == 8'd6)
         checkOutput({tag, " tags_2_3_6"},
                     (res_log.size() == 3) ? {8'h0, res_log[0], res_log[1], res_log[2]} : 32'hffff_ffff,
                     32'h0002_0306);
      @(negedge clk);
      checkOutput({tag, " done_pulse"}, done, 0);
      checkOutput({tag, " qx_hold"}, qx, v.eqx);
   endtask

   function automatic vec_t mkVec(input logic [7:0] kv, input int lat,
                                  input int mid);
      vec_t v;
      v.k = kv; v.px = 8'd1; v.py = 8'd2; v.lat = lat; v.mid_start = mid;
      v.eqx = kv; v.eqy = 8'(2 * kv); v.einf = (kv == 0); v.ecnt = 0;
      return v;
   endfunction

   initial begin
      vec_t v;
      int   mcnt;
      int   guard;
      bit   seen_done, seen_busy;

      vecs[0] = '{8'd0,   8'h5A, 8'hA5, 1, 0, 8'h00, 8'h00, 1'b1, 0};
      vecs[1] = '{8'd1,   8'h3C, 8'hC3, 1, 0, 8'h3C, 8'hC3, 1'b0, 0};
      vecs[2] = '{8'd5,   8'h01, 8'h02, 3, 0, 8'd5,  8'd10, 1'b0, 3};
      vecs[3] = '{8'd6,   8'h01, 8'h02, 2, 0, 8'd6,  8'd12, 1'b0, 3};
      vecs[4] = '{8'd255, 8'h01, 8'h02, 1, 5, 8'd255, 8'd254, 1'b0, 14};
      vecs[5] = '{8'd3,   8'h01, 8'h02, 1, 0, 8'd3,  8'd6,  1'b0, 2};
      vecs[6] = '{8'd128, 8'h01, 8'h02, 4, 0, 8'd128, 8'd0, 1'b0, 7};
      vecs[7] = '{8'd2,   8'h01, 8'h02, 1, 0, 8'd2,  8'd4,  1'b0, 1};

      start = 0; k = 0; px = 0; py = 0;
      reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      checkOutput("rst busy", busy, 0);
      checkOutput("rst done", done, 0);
      checkOutput("rst op_start", op_start, 0);
      checkOutput("rst q_inf", q_inf, 0);
      checkOutput("rst qx", qx, 0);
      checkOutput("rst op_count", op_count, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 8; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 20; i++) begin
         v = mkVec(8'($urandom_range(0, 255)), int'($urandom_range(1, 4)), 0);
         buildExpected(v.k, mcnt);
         v.ecnt = mcnt;
         applyStimulus(v, $sformatf("rand%0d k=%0d", i, v.k));
      end

      // Reset during the second wait of a k=6 job; the late op_done must not
      // revive the job.
      op_lat = 6;
      sel_log.delete();
      @(negedge clk);
      k = 8'd6; px = 8'd1; py = 8'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (sel_log.size() < 2 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("rstmid second_op", sel_log.size(), 2);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("rstmid busy", busy, 0);
      checkOutput("rstmid op_start", op_start, 0);
      checkOutput("rstmid op_sel", op_sel, 0);
      checkOutput("rstmid qx", qx, 0);
      checkOutput("rstmid qy", qy, 0);
      checkOutput("rstmid op_ax", op_ax, 0);
      checkOutput("rstmid op_ay", op_ay, 0);
      checkOutput("rstmid op_bx", op_bx, 0);
      checkOutput("rstmid op_by", op_by, 0);
      checkOutput("rstmid op_count", op_count, 0);
      @(negedge clk);
      reset = 1'b1;
      seen_done = 0;
      seen_busy = 0;
      repeat (20) begin
         @(negedge clk);
         if (done === 1'b1) seen_done = 1;
         if (busy === 1'b1) seen_busy = 1;
      end
      checkOutput("rstmid no_done", seen_done, 0);
      checkOutput("rstmid stays_idle", seen_busy, 0);
      applyStimulus(vecs[5], "after_reset k=3");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
